// File: rtl/matrix_result_store.sv
// matrix_result_store: latches a block of result vectors and commits
// them one row per clock into a register-file memory with a comb read port.
module matrix_result_store #(
  parameter int VLEN      = 128,
  parameter int VEC_COUNT = 4,
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [VEC_COUNT*VLEN-1:0]   vec_in,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           wr_ptr,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [VLEN-1:0]             rd_data
);

  localparam int IDX_W = (VEC_COUNT > 1) ? $clog2(VEC_COUNT) : 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] idx;
  logic [VLEN-1:0]  lat [VEC_COUNT];
  logic [VLEN-1:0]  mem [MEM_DEPTH];
  logic             take;
  logic             wr;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    wr       = 1'b0;
    last     = (idx == IDX_W'(VEC_COUNT - 1));
    unique case (state)
      IDLE: begin
        if (start) begin
          take     = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        wr = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == WRITE);

  // wr_ptr doubles as the write address; it holds after the last row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      wr_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= wr && last;
      if (take) begin
        idx    <= '0;
        wr_ptr <= base_addr;
      end else if (wr && !last) begin
        idx    <= idx + IDX_W'(1);
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_COUNT; i++) lat[i] <= '0;
    end else if (take) begin
      for (int i = 0; i < VEC_COUNT; i++)
        lat[i] <= vec_in[i*VLEN +: VLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= lat[idx];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_matrix_result_store.sv
// tb_matrix_result_store: scoreboard bench for matrix_result_store.
// Expected row writes are queued at start and popped while busy.
module tb_matrix_result_store;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   base_addr;
  logic [511:0] vec_in;
  logic         busy;
  logic         done;
  logic [4:0]   wr_ptr;
  logic [4:0]   rd_addr;
  logic [127:0] rd_data;

  typedef struct {
    logic [4:0]   a;
    logic [127:0] d;
  } wr_t;

  wr_t          q[$];
  logic [127:0] mm [32];
  int           n_chk;
  int           n_err;
  int           done_cnt;
  int           snap;

  matrix_result_store dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .vec_in    (vec_in),
    .busy      (busy),
    .done      (done),
    .wr_ptr    (wr_ptr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] row(input int a, b, c, d);
    return {32'(a), 32'(b), 32'(c), 32'(d)};
  endfunction

  task automatic drive(input logic [4:0] b,
                       input logic [127:0] r0, r1, r2, r3,
                       input bit push);
    wr_t e;
    logic [127:0] rr [4];
    rr[0] = r0; rr[1] = r1; rr[2] = r2; rr[3] = r3;
    start     = 1'b1;
    base_addr = b;
    for (int i = 0; i < 4; i++) begin
      vec_in[i*128 +: 128] = rr[i];
      if (push) begin
        e.a = b + 5'(i);
        e.d = rr[i];
        q.push_back(e);
      end
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1;
      check(tag, rd_data, mm[a]);
    end
  endtask

  // consume one expected write per busy cycle
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (rst_n && busy) begin
      if (q.size() == 0) begin
        check("wq_underflow", 128'(1), 128'(0));
      end else begin
        e = q.pop_front();
        check("wr_ptr", 128'(wr_ptr), 128'(e.a));
        mm[e.a] = e.d;
      end
    end
  end

  initial begin
    n_chk = 0; n_err = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    vec_in = '0; rd_addr = '0;
    for (int i = 0; i < 32; i++) mm[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_wrptr", 128'(wr_ptr), 128'(0));
    check_mem("rst_mem");

    // basic store at 8, inputs scrambled while busy
    @(negedge clk);
    drive(5'd8, row(4,3,2,1), row(8,7,6,5),
          row(12,11,10,9), row(16,15,14,13), 1);
    @(negedge clk);
    start = 1'b0; vec_in = '1; base_addr = 5'd3;
    check("b_busy1", 128'(busy), 128'(1));
    check("b_done1", 128'(done), 128'(0));
    rd_addr = 5'd8;
    #1 check("rdw_old", rd_data, 128'(0));
    @(negedge clk);
    check("b_busy2", 128'(busy), 128'(1));
    #1 check("rdw_new", rd_data, row(4,3,2,1));
    @(negedge clk);
    check("b_busy3", 128'(busy), 128'(1));
    @(negedge clk);
    check("b_busy4", 128'(busy), 128'(1));
    check("b_done4", 128'(done), 128'(0));
    @(negedge clk);
    check("b_busy5", 128'(busy), 128'(0));
    check("b_done5", 128'(done), 128'(1));
    @(negedge clk);
    check("b_done6", 128'(done), 128'(0));
    check_mem("b_mem");

    // wrap-around at 30
    drive(5'd30, row(1,2,3,4), 128'hA5A5_0001, 128'hFFFF_0000_1234,
          {4{32'hDEAD_BEEF}}, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("wrap_hold", 128'(wr_ptr), 128'(1));
    check_mem("wrap_mem");

    // start while busy is ignored
    snap = done_cnt;
    drive(5'd12, row(9,9,9,1), row(9,9,9,2), row(9,9,9,3), row(9,9,9,4), 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(5'd20, row(7,7,7,7), row(6,6,6,6), row(5,5,5,5), row(4,4,4,4), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("ign_done", 128'(done_cnt - snap), 128'(1));
    check_mem("ign_mem");

    // back-to-back via start in the done cycle
    drive(5'd24, row(24,0,0,1), row(24,0,0,2), row(24,0,0,3), row(24,0,0,4), 1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("b2b_done", 128'(done), 128'((c == 5) || (c == 10)));
      if (c == 5)
        drive(5'd16, row(16,0,0,1), row(16,0,0,2),
              row(16,0,0,3), row(16,0,0,4), 1);
      else
        start = 1'b0;
    end
    check_mem("b2b_mem");

    // reset mid-transaction
    drive(5'd4, row(4,4,4,1), row(4,4,4,2), row(4,4,4,3), row(4,4,4,4), 1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    q.delete();
    for (int i = 0; i < 32; i++) mm[i] = '0;
    snap = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_nodone", 128'(done_cnt - snap), 128'(0));
    check("abort_idle", 128'(busy), 128'(0));
    check_mem("abort_mem");
    check("q_empty", 128'(q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
